hsc_responder: RTL and testbench

- Bus-side responder for the High Score Cartridge (HSC). Answers 7800 bus cycles driven by the CPU or MARIA on the shared AB/RW/write-data bus, in the same memclk domain as on-board RAM0/RAM1.
- Owns the 2 KB battery-backed score SRAM at $1000-$17FF.
- Forwards HSC ROM accesses at $3000-$3FFF to external storage.
- Runs a host-side save/load engine that streams SRAM contents to or from the framework while the console runs.

---
 rtl/hsc_responder_if.sv | 41 ++++
 rtl/hsc_responder.sv | 170 +++++++++++++++++
 tb/tb_hsc_responder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsc_responder_if.sv
// Bus and host-side signal bundle for the High Score Cartridge responder.
// The slave modport is the responder; the master modport is whoever drives the bus and the host link.
interface hsc_responder_if #(
   parameter int RAM_AW = 11
);
   logic              enable;
   logic [15:0]       ab;
   logic              rw;
   logic [7:0]        din;
   logic              ram_hit;
   logic              rom_hit;
   logic [7:0]        dout;
   logic [11:0]       rom_addr;
   logic [7:0]        rom_data;
   logic              save_req;
   logic              load_req;
   logic              busy;
   logic              done;
   logic              dirty;
   logic [RAM_AW-1:0] host_addr;
   logic [7:0]        host_rd_data;
   logic              host_rd_valid;
   logic              host_rd_ready;
   logic [7:0]        host_wr_data;
   logic              host_wr_valid;
   logic              host_wr_ready;

   modport slave (
      input  enable, ab, rw, din, rom_data, save_req, load_req,
             host_rd_ready, host_wr_data, host_wr_valid,
      output ram_hit, rom_hit, dout, rom_addr, busy, done, dirty,
             host_addr, host_rd_data, host_rd_valid, host_wr_ready
   );

   modport master (
      output enable, ab, rw, din, rom_data, save_req, load_req,
             host_rd_ready, host_wr_data, host_wr_valid,
      input  ram_hit, rom_hit, dout, rom_addr, busy, done, dirty,
             host_addr, host_rd_data, host_rd_valid, host_wr_ready
   );
endinterface

// File: rtl/hsc_responder.sv
// HSC bus responder: battery-backed score SRAM, ROM window forwarding,
// and a host save/load engine sharing the single SRAM port behind the bus.
module hsc_responder #(
   parameter int          RAM_AW   = 11,
   parameter logic [15:0] RAM_BASE = 16'h1000,
   parameter logic [15:0] ROM_BASE = 16'h3000
) (
   input logic            memclk,
   input logic            reset,
   hsc_responder_if.slave bus
);

   localparam int unsigned DEPTH = 1 << RAM_AW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAVE_RD,
      S_SAVE_HOLD,
      S_LOAD,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_RAM,
      SRC_ROM
   } src_t;

   state_t            state_q;
   src_t              src_q;
   logic [7:0]        mem [DEPTH];
   logic [7:0]        bus_rd_q;
   logic [7:0]        save_rd_q;
   logic [7:0]        dout_hold_q;
   logic [7:0]        dout_d;
   logic              busy_q;
   logic              done_q;
   logic              dirty_q;
   logic              rd_valid_q;
   logic [RAM_AW-1:0] host_addr_q;
   logic [RAM_AW-1:0] host_addr_d;

   logic              ram_hit;
   logic              rom_hit;
   logic              bus_wr;
   logic              bus_rd;
   logic              save_rd_en;
   logic              load_we;
   logic              ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [7:0]        ram_wdata;

   assign ram_hit = bus.enable && (bus.ab[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
   assign rom_hit = bus.enable && (bus.ab[15:12] == ROM_BASE[15:12]);
   assign bus_wr  = ram_hit && !bus.rw;
   assign bus_rd  = ram_hit && bus.rw;

   // The host engine only touches the SRAM in cycles the bus leaves free.
   assign save_rd_en = (state_q == S_SAVE_RD) && !ram_hit;
   assign load_we    = (state_q == S_LOAD) && bus.host_wr_valid && !ram_hit;

   assign ram_addr    = ram_hit ? bus.ab[RAM_AW-1:0] : host_addr_q;
   assign ram_we      = bus_wr || load_we;
   assign ram_wdata   = ram_hit ? bus.din : bus.host_wr_data;
   assign host_addr_d = host_addr_q + RAM_AW'(1);

   // Separate capture registers keep a held save byte stable across bus reads.
   always_ff @(posedge memclk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (bus_rd) bus_rd_q <= mem[ram_addr];
      if (save_rd_en) save_rd_q <= mem[ram_addr];
   end

   always_comb begin
      dout_d = dout_hold_q;
      unique case (src_q)
         SRC_RAM: dout_d = bus_rd_q;
         SRC_ROM: dout_d = bus.rom_data;
         default: dout_d = dout_hold_q;
      endcase
   end

   always_ff @(posedge memclk or posedge reset) begin
      if (reset) begin
         src_q       <= SRC_NONE;
         dout_hold_q <= '0;
      end else begin
         dout_hold_q <= dout_d;
         if (bus_rd)                  src_q <= SRC_RAM;
         else if (rom_hit && bus.rw)  src_q <= SRC_ROM;
         else                         src_q <= SRC_NONE;
      end
   end

   always_ff @(posedge memclk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dirty_q     <= 1'b0;
         rd_valid_q  <= 1'b0;
         host_addr_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.save_req) begin
                  host_addr_q <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= S_SAVE_RD;
               end else if (bus.load_req) begin
                  host_addr_q <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= S_LOAD;
               end
            end
            S_SAVE_RD: begin
               if (save_rd_en) begin
                  rd_valid_q <= 1'b1;
                  state_q    <= S_SAVE_HOLD;
               end
            end
            S_SAVE_HOLD: begin
               if (bus.host_rd_ready) begin
                  rd_valid_q <= 1'b0;
                  if (&host_addr_q) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     host_addr_q <= host_addr_d;
                     state_q     <= S_SAVE_RD;
                  end
               end
            end
            S_LOAD: begin
               if (load_we) begin
                  if (&host_addr_q) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     host_addr_q <= host_addr_d;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // A bus write landing with a save start still counts as unsaved.
         if (bus_wr)                               dirty_q <= 1'b1;
         else if (state_q == S_IDLE && bus.save_req) dirty_q <= 1'b0;
      end
   end

   assign bus.ram_hit       = ram_hit;
   assign bus.rom_hit       = rom_hit;
   assign bus.rom_addr      = bus.ab[11:0];
   assign bus.dout          = dout_d;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.dirty         = dirty_q;
   assign bus.host_addr     = host_addr_q;
   assign bus.host_rd_data  = save_rd_q;
   assign bus.host_rd_valid = rd_valid_q;
   assign bus.host_wr_ready = load_we;

endmodule

// File: tb/tb_hsc_responder.sv
// Self-checking bench for hsc_responder: randomized bus and host traffic
// compared against an array model of the score SRAM.
module tb_hsc_responder;
   localparam int AW = 11;
   localparam int N  = 1 << AW;

   logic memclk = 1'b0;
   logic reset;
   always #5 memclk = ~memclk;

   hsc_responder_if #(.RAM_AW(AW)) bif ();

   hsc_responder #(
      .RAM_AW(AW),
      .RAM_BASE(16'h1000),
      .ROM_BASE(16'h3000)
   ) dut (
      .memclk(memclk),
      .reset(reset),
      .bus(bif.slave)
   );

   int checks   = 0;
   int failures = 0;
   logic [7:0] model [N];

   task automatic drive_idle();
      bif.enable        = 1'b1;
      bif.ab            = 16'h0000;
      bif.rw            = 1'b1;
      bif.din           = 8'h00;
      bif.rom_data      = 8'h00;
      bif.save_req      = 1'b0;
      bif.load_req      = 1'b0;
      bif.host_rd_ready = 1'b0;
      bif.host_wr_data  = 8'h00;
      bif.host_wr_valid = 1'b0;
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
      @(negedge memclk);
      bif.ab  = addr;
      bif.rw  = 1'b0;
      bif.din = data;
      if (addr >= 16'h1000 && addr <= 16'h17FF) model[addr - 16'h1000] = data;
      @(posedge memclk);
      #1;
      bif.ab = 16'h0000;
      bif.rw = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      repeat (3) @(negedge memclk);
      #1;
      checks++; if (bif.dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h exp 00", bif.dout); end
      checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", bif.busy); end
      checks++; if (bif.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b exp 0", bif.done); end
      checks++; if (bif.dirty !== 1'b0) begin failures++; $display("FAIL reset_dirty: got %b exp 0", bif.dirty); end
      checks++; if (bif.host_addr !== '0) begin failures++; $display("FAIL reset_host_addr: got %h exp 0", bif.host_addr); end
      checks++; if (bif.host_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b exp 0", bif.host_rd_valid); end
      checks++; if (bif.host_wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready: got %b exp 0", bif.host_wr_ready); end
      @(negedge memclk);
      reset = 1'b0;
   endtask

   task automatic test_bus();
      logic [15:0] a;
      logic [7:0]  d;
      bus_write(16'h1005, 8'hA5);
      @(negedge memclk);
      bif.ab = 16'h1005; bif.rw = 1'b1;
      #1;
      checks++; if (bif.ram_hit !== 1'b1) begin failures++; $display("FAIL hit_1005: got %b exp 1", bif.ram_hit); end
      @(posedge memclk); #1;
      bif.ab = 16'h0000;
      checks++; if (bif.dout !== 8'hA5) begin failures++; $display("FAIL read_1005: got %h exp a5", bif.dout); end
      checks++; if (bif.dirty !== 1'b1) begin failures++; $display("FAIL dirty_after_write: got %b exp 1", bif.dirty); end
      @(posedge memclk); #1;
      checks++; if (bif.dout !== 8'hA5) begin failures++; $display("FAIL dout_hold: got %h exp a5", bif.dout); end
      @(negedge memclk);
      bif.ab = 16'h17FF; #1;
      checks++; if (bif.ram_hit !== 1'b1) begin failures++; $display("FAIL hit_17ff: got %b exp 1", bif.ram_hit); end
      bif.ab = 16'h1800; #1;
      checks++; if (bif.ram_hit !== 1'b0) begin failures++; $display("FAIL hit_1800: got %b exp 0", bif.ram_hit); end
      bif.ab = 16'h0FFF; #1;
      checks++; if (bif.ram_hit !== 1'b0) begin failures++; $display("FAIL hit_0fff: got %b exp 0", bif.ram_hit); end
      bif.enable = 1'b0; bif.ab = 16'h1005; #1;
      checks++; if (bif.ram_hit !== 1'b0) begin failures++; $display("FAIL hit_disabled: got %b exp 0", bif.ram_hit); end
      bif.enable = 1'b1; bif.ab = 16'h0000;
      for (int i = 0; i < 40; i++) begin
         a = 16'h1000 + 16'($urandom_range(0, 63));
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 0 || model[a - 16'h1000] === 8'hxx) begin
            bus_write(a, d);
         end else begin
            @(negedge memclk);
            bif.ab = a; bif.rw = 1'b1;
            @(posedge memclk); #1;
            bif.ab = 16'h0000;
            checks++;
            if (bif.dout !== model[a - 16'h1000]) begin
               failures++; $display("FAIL rand_read %h: got %h exp %h", a, bif.dout, model[a - 16'h1000]);
            end
         end
      end
   endtask

   task automatic test_rom();
      bus_write(16'h12BC, 8'h5A);
      @(negedge memclk);
      bif.ab = 16'h3ABC; bif.rw = 1'b1; bif.rom_data = 8'h3C;
      #1;
      checks++; if (bif.rom_addr !== 12'hABC) begin failures++; $display("FAIL rom_addr: got %h exp abc", bif.rom_addr); end
      checks++; if (bif.rom_hit !== 1'b1) begin failures++; $display("FAIL rom_hit: got %b exp 1", bif.rom_hit); end
      checks++; if (bif.ram_hit !== 1'b0) begin failures++; $display("FAIL rom_not_ram: got %b exp 0", bif.ram_hit); end
      @(posedge memclk); #1;
      bif.ab = 16'h0000;
      checks++; if (bif.dout !== 8'h3C) begin failures++; $display("FAIL rom_dout: got %h exp 3c", bif.dout); end
      @(posedge memclk); #1;
      bif.rom_data = 8'h55;
      checks++; if (bif.dout !== 8'h3C) begin failures++; $display("FAIL rom_dout_hold: got %h exp 3c", bif.dout); end
      @(negedge memclk);
      bif.ab = 16'h3ABC; bif.rw = 1'b0; bif.din = 8'h77;
      @(posedge memclk); #1;
      bif.ab = 16'h0000; bif.rw = 1'b1;
      @(negedge memclk);
      bif.ab = 16'h12BC;
      @(posedge memclk); #1;
      bif.ab = 16'h0000;
      checks++; if (bif.dout !== 8'h5A) begin failures++; $display("FAIL rom_write_ignored: got %h exp 5a", bif.dout); end
   endtask

   // Streams a whole save; optionally randomizes host_rd_ready and interleaves bus reads.
   task automatic run_save(input bit rand_ready, input bit bus_reads);
      int idx = 0, donecnt = 0, cyc = 0;
      bit pend = 0, pend_now, hold = 0;
      logic [7:0] pexp = 8'h00, pexp_now = 8'h00, hold_data = 8'h00;
      int pa;
      @(negedge memclk);
      bif.save_req = 1'b1;
      @(negedge memclk);
      bif.save_req = 1'b0;
      while (donecnt == 0 && cyc < 20000) begin
         bif.host_rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         pend_now = 0;
         if (bus_reads && $urandom_range(0, 2) == 0) begin
            pa = $urandom_range(0, 16);
            bif.ab = 16'h1000 + 16'(pa); bif.rw = 1'b1;
            pend_now = 1; pexp_now = model[pa];
         end else begin
            bif.ab = 16'h0000;
         end
         #1;
         if (pend) begin
            checks++;
            if (bif.dout !== pexp) begin failures++; $display("FAIL save_bus_read: got %h exp %h", bif.dout, pexp); end
         end
         if (hold) begin
            checks++;
            if (bif.host_rd_valid !== 1'b1 || bif.host_rd_data !== hold_data) begin
               failures++; $display("FAIL save_hold_stable: valid %b data %h exp 1 %h", bif.host_rd_valid, bif.host_rd_data, hold_data);
            end
         end
         if (bif.done === 1'b1) donecnt++;
         hold = 0;
         if (bif.host_rd_valid === 1'b1 && bif.host_rd_ready) begin
            checks++;
            if (idx >= N || bif.host_rd_data !== model[idx] || bif.host_addr !== AW'(idx)) begin
               failures++; $display("FAIL save_byte %0d: addr %h data %h exp data %h", idx, bif.host_addr, bif.host_rd_data, (idx < N) ? model[idx] : 8'hxx);
            end
            idx++;
         end else if (bif.host_rd_valid === 1'b1) begin
            hold = 1; hold_data = bif.host_rd_data;
         end
         pend = pend_now; pexp = pexp_now;
         @(negedge memclk);
         cyc++;
      end
      bif.ab = 16'h0000; bif.host_rd_ready = 1'b0;
      #1;
      checks++; if (idx !== N) begin failures++; $display("FAIL save_count: got %0d exp %0d", idx, N); end
      checks++; if (donecnt !== 1) begin failures++; $display("FAIL save_done: got %0d exp 1", donecnt); end
      checks++; if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin failures++; $display("FAIL save_end: busy %b done %b exp 0 0", bif.busy, bif.done); end
      checks++; if (bif.dirty !== 1'b0) begin failures++; $display("FAIL save_dirty: got %b exp 0", bif.dirty); end
   endtask

   task automatic test_save_full();
      for (int i = 0; i < N; i++) bus_write(16'h1000 + 16'(i), 8'(i));
      run_save(1'b0, 1'b0);
   endtask

   task automatic test_save_interleaved();
      run_save(1'b1, 1'b1);
   endtask

   task automatic test_load();
      int idx = 0, donecnt = 0, cyc = 0, pa = 0;
      bit pend = 0, hit;
      logic [7:0] pexp = 8'h00, pexp_now;
      @(negedge memclk);
      bif.load_req = 1'b1;
      @(negedge memclk);
      bif.load_req = 1'b0;
      while (donecnt == 0 && cyc < 20000) begin
         bif.save_req = (cyc == 5);
         bif.host_wr_valid = (idx < N) && ($urandom_range(0, 3) != 0);
         bif.host_wr_data  = 8'hFF - 8'(idx);
         hit = ($urandom_range(0, 3) == 0);
         if (hit) begin
            pa = $urandom_range(0, N - 1);
            bif.ab = 16'h1000 + 16'(pa); bif.rw = 1'b1;
            pexp_now = model[pa];
         end else begin
            bif.ab = 16'h0000;
            pexp_now = 8'h00;
         end
         #1;
         if (pend) begin
            checks++;
            if (bif.dout !== pexp) begin failures++; $display("FAIL load_bus_read: got %h exp %h", bif.dout, pexp); end
         end
         checks++;
         if (bif.host_wr_ready !== (bif.host_wr_valid && !hit)) begin
            failures++; $display("FAIL load_wr_ready %0d: got %b exp %b", idx, bif.host_wr_ready, bif.host_wr_valid && !hit);
         end
         if (bif.done === 1'b1) donecnt++;
         if (bif.host_wr_valid && !hit) begin
            model[idx] = bif.host_wr_data;
            idx++;
         end
         pend = hit; pexp = pexp_now;
         @(negedge memclk);
         cyc++;
      end
      bif.ab = 16'h0000; bif.host_wr_valid = 1'b0; bif.save_req = 1'b0;
      checks++; if (idx !== N) begin failures++; $display("FAIL load_count: got %0d exp %0d", idx, N); end
      checks++; if (donecnt !== 1) begin failures++; $display("FAIL load_done: got %0d exp 1", donecnt); end
      for (int k = 0; k < 12; k++) begin
         pa = $urandom_range(0, N - 1);
         @(negedge memclk);
         bif.ab = 16'h1000 + 16'(pa); bif.rw = 1'b1;
         @(posedge memclk); #1;
         bif.ab = 16'h0000;
         checks++;
         if (bif.dout !== 8'hFF - 8'(pa)) begin failures++; $display("FAIL load_readback %h: got %h exp %h", pa, bif.dout, 8'hFF - 8'(pa)); end
      end
   endtask

   task automatic test_reset_mid_save();
      int cyc = 0;
      bit seen = 0, done_seen = 0;
      @(negedge memclk);
      bif.save_req = 1'b1; bif.host_rd_ready = 1'b1;
      @(negedge memclk);
      bif.save_req = 1'b0;
      while (cyc < 5000) begin
         #1;
         if (bif.host_addr === AW'(16'h200)) break;
         @(negedge memclk);
         cyc++;
      end
      checks++; if (bif.host_addr !== AW'(16'h200)) begin failures++; $display("FAIL mid_reach_200: got %h exp 200", bif.host_addr); end
      reset = 1'b1;
      #1;
      checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b exp 0", bif.busy); end
      checks++; if (bif.host_rd_valid !== 1'b0) begin failures++; $display("FAIL mid_rd_valid: got %b exp 0", bif.host_rd_valid); end
      for (int k = 0; k < 3; k++) begin
         @(negedge memclk); #1;
         if (bif.done !== 1'b0) done_seen = 1;
      end
      checks++; if (done_seen) begin failures++; $display("FAIL mid_done: got 1 exp 0"); end
      @(negedge memclk);
      reset = 1'b0;
      @(negedge memclk);
      bif.save_req = 1'b1;
      @(negedge memclk);
      bif.save_req = 1'b0;
      #1;
      checks++; if (bif.host_addr !== '0 || bif.busy !== 1'b1) begin failures++; $display("FAIL restart: addr %h busy %b exp 0 1", bif.host_addr, bif.busy); end
      for (int k = 0; k < 10 && !seen; k++) begin
         if (bif.host_rd_valid === 1'b1) begin
            seen = 1;
            checks++;
            if (bif.host_rd_data !== model[0]) begin failures++; $display("FAIL restart_byte0: got %h exp %h", bif.host_rd_data, model[0]); end
         end else begin
            @(negedge memclk); #1;
         end
      end
      checks++; if (!seen) begin failures++; $display("FAIL restart_timeout: got no valid exp valid"); end
      reset = 1'b1;
      drive_idle();
      @(negedge memclk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bus();
      test_rom();
      test_save_full();
      test_save_interleaved();
      test_load();
      test_reset_mid_save();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
